// File: rtl/cp0_interrupt_unit_pkg.sv
// Shared constants for the CP0 interrupt block: register numbers, default
// handler vectors and the default source count.
package cp0_pkg;
  localparam int          CP0_N_SRC = 3;

  localparam logic [4:0]  CP0_EPC   = 5'h0e;
  localparam logic [4:0]  CP0_PEND  = 5'h0d;
  localparam logic [4:0]  CP0_DIS   = 5'h16;
  localparam logic [4:0]  CP0_MASK  = 5'h17;

  localparam logic [31:0] CP0_VEC2  = 32'h0000_0400;
  localparam logic [31:0] CP0_VEC1  = 32'h0000_0600;
  localparam logic [31:0] CP0_VEC0  = 32'h0000_0800;
endpackage

// File: rtl/cp0_interrupt_unit_if.sv
// ID-stage <-> CP0 signal bundle. master = ID stage, slave = CP0 block.
interface cp0_interrupt_unit_if;
  // Handshake: ID raises take_en when its instruction may be replaced. CP0
  // answers combinationally with irq_take. A redirect happens only in a cycle
  // where both take_en and irq_take are high, and it commits on that clock edge.
  logic        take_en;
  logic [31:0] resume_pc;
  logic        exce_ret;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        irq_take;
  logic [31:0] irq_target;
  logic [31:0] epc;
  logic        irq_disable;

  modport master (
    output take_en, resume_pc, exce_ret, cp0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, irq_take, irq_target, epc, irq_disable
  );

  modport slave (
    input  take_en, resume_pc, exce_ret, cp0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, irq_take, irq_target, epc, irq_disable
  );
endinterface

// File: rtl/cp0_interrupt_unit_irq_sync_edge.sv
// Two-flop synchroniser for one async interrupt line, plus a delay flop
// that turns the synchronised level into a one-cycle rising-edge pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_async,
  output logic irq_edge
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign irq_edge = s2 & ~s3;
endmodule

// File: rtl/cp0_interrupt_unit.sv
// CP0 interrupt unit: edge-latched pending requests, mask/disable gating,
// fixed-priority selection, EPC save and mtc0/mfc0/eret register handling.
module cp0_interrupt_unit
  import cp0_pkg::*;
#(
  parameter int                 N_SRC    = CP0_N_SRC,
  parameter logic [31:0]        VEC2     = CP0_VEC2,
  parameter logic [31:0]        VEC1     = CP0_VEC1,
  parameter logic [31:0]        VEC0     = CP0_VEC0,
  parameter logic [N_SRC-1:0]   MASK_RST = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  irq_in,
  cp0_interrupt_unit_if.slave bus
);
  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] irq_edge;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] mask_q;
  logic             dis_q;
  logic [31:0]      epc_q;

  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [SEL_W-1:0] sel;
  logic             take;
  logic [31:0]      target;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_async (irq_in[g]),
      .irq_edge  (irq_edge[g])
    );
  end

  assign eligible = pending_q & mask_q & {N_SRC{~dis_q}};
  assign take     = (|eligible) & bus.take_en & ~bus.exce_ret;

  // Ascending scan: the last eligible index seen is the highest priority one.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i]) sel = i[SEL_W-1:0];
    end
  end

  always_comb begin
    target = 32'h0;
    clr    = '0;
    if (take) begin
      clr[sel] = 1'b1;
      if (sel == SEL_W'(2))      target = VEC2;
      else if (sel == SEL_W'(1)) target = VEC1;
      else                       target = VEC0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      mask_q    <= MASK_RST;
      dis_q     <= 1'b0;
      epc_q     <= 32'h0;
    end else begin
      // A fresh edge on a source overrides its clear in the same cycle.
      pending_q <= irq_edge | (pending_q & ~clr);
      if (bus.cp0_we && bus.cp0_addr == CP0_MASK)
        mask_q <= bus.cp0_wdata[N_SRC-1:0];
      if (take) begin
        dis_q <= 1'b1;
        epc_q <= bus.resume_pc;
      end else begin
        if (bus.exce_ret)
          dis_q <= 1'b0;
        else if (bus.cp0_we && bus.cp0_addr == CP0_DIS)
          dis_q <= bus.cp0_wdata[0];
        if (bus.cp0_we && bus.cp0_addr == CP0_EPC)
          epc_q <= bus.cp0_wdata;
      end
    end
  end

  always_comb begin
    bus.cp0_rdata = 32'h0;
    case (bus.cp0_addr)
      CP0_DIS:  bus.cp0_rdata = {31'b0, dis_q};
      CP0_MASK: bus.cp0_rdata = 32'(mask_q);
      CP0_EPC:  bus.cp0_rdata = epc_q;
      CP0_PEND: bus.cp0_rdata = 32'(pending_q);
      default:  bus.cp0_rdata = 32'h0;
    endcase
  end

  assign bus.irq_take    = take;
  assign bus.irq_target  = target;
  assign bus.epc         = epc_q;
  assign bus.irq_disable = dis_q;
endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// Directed bench for cp0_interrupt_unit: a register-access vector table
// followed by hand-written interrupt timing sequences.
module tb_cp0_interrupt_unit;
  logic       clk;
  logic       rst_n;
  logic [2:0] irq_in;
  int         total;
  int         bad;

  cp0_interrupt_unit_if bus();

  cp0_interrupt_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_in (irq_in),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [4:0] addr, input logic [31:0] exp);
    bus.cp0_addr = addr;
    #1;
    chk(name, bus.cp0_rdata, exp);
  endtask

  task automatic eret();
    bus.exce_ret = 1'b1;
    step();
    bus.exce_ret = 1'b0;
  endtask

  // ---------------- register access table ----------------
  typedef struct {
    string       name;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[8];

  initial begin
    int first_take;
    int n_take;

    vecs[0] = '{"mask_write5",   5'h17, 32'h0000_0005, 5'h17, 32'h0000_0005};
    vecs[1] = '{"mask_trunc",    5'h17, 32'hFFFF_FFF8, 5'h17, 32'h0000_0000};
    vecs[2] = '{"dis_set",       5'h16, 32'h0000_0001, 5'h16, 32'h0000_0001};
    vecs[3] = '{"dis_clr_bit0",  5'h16, 32'hFFFF_FFFE, 5'h16, 32'h0000_0000};
    vecs[4] = '{"epc_write",     5'h0e, 32'h1234_5678, 5'h0e, 32'h1234_5678};
    vecs[5] = '{"pend_readonly", 5'h0d, 32'h0000_0007, 5'h0d, 32'h0000_0000};
    vecs[6] = '{"unmapped_rd",   5'h05, 32'hFFFF_FFFF, 5'h05, 32'h0000_0000};
    vecs[7] = '{"mask_restore",  5'h17, 32'h0000_0007, 5'h17, 32'h0000_0007};

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    irq_in = 3'b000;
    bus.take_en   = 1'b0;
    bus.resume_pc = 32'h0;
    bus.exce_ret  = 1'b0;
    bus.cp0_we    = 1'b0;
    bus.cp0_addr  = 5'h0;
    bus.cp0_wdata = 32'h0;

    // Reset state
    step(2);
    rd("rst_mask", 5'h17, 32'h7);
    rd("rst_dis",  5'h16, 32'h0);
    rd("rst_epc",  5'h0e, 32'h0);
    rd("rst_pend", 5'h0d, 32'h0);
    chk("rst_take",   {31'b0, bus.irq_take}, 32'h0);
    chk("rst_target", bus.irq_target, 32'h0);
    rst_n = 1'b1;
    step();

    // Register access vectors
    for (int v = 0; v < 8; v++) begin
      bus.cp0_we    = 1'b1;
      bus.cp0_addr  = vecs[v].waddr;
      bus.cp0_wdata = vecs[v].wdata;
      step();
      bus.cp0_we = 1'b0;
      rd(vecs[v].name, vecs[v].raddr, vecs[v].exp);
    end

    // Single source 1: take exactly once, three edges after the rise
    bus.take_en   = 1'b1;
    bus.resume_pc = 32'h0000_0040;
    irq_in[1]     = 1'b1;
    first_take = 0;
    n_take     = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      #1;
      if (bus.irq_take) begin
        n_take++;
        if (first_take == 0) begin
          first_take = c;
          chk("s1_target", bus.irq_target, 32'h0000_0600);
        end
      end
    end
    chk("s1_take_cycle", 32'(first_take), 32'd3);
    chk("s1_take_count", 32'(n_take), 32'd1);
    chk("s1_epc", bus.epc, 32'h0000_0040);
    chk("s1_dis", {31'b0, bus.irq_disable}, 32'h1);
    rd("s1_pend", 5'h0d, 32'h0);

    // Sources 0 and 2 together: 2 first, then 0 after eret
    irq_in = 3'b000;
    eret();
    rd("eret_dis", 5'h16, 32'h0);
    step(2);
    irq_in = 3'b101;
    step(3);
    #1;
    chk("p20_take2", {31'b0, bus.irq_take}, 32'h1);
    chk("p20_tgt2", bus.irq_target, 32'h0000_0400);
    step();
    #1;
    chk("p20_hold", {31'b0, bus.irq_take}, 32'h0);
    rd("p20_pend", 5'h0d, 32'h1);
    bus.exce_ret = 1'b1;
    #1;
    chk("p20_eret_notake", {31'b0, bus.irq_take}, 32'h0);
    step();
    bus.exce_ret = 1'b0;
    #1;
    chk("p20_take0", {31'b0, bus.irq_take}, 32'h1);
    chk("p20_tgt0", bus.irq_target, 32'h0000_0800);
    step();
    rd("p20_pend_done", 5'h0d, 32'h0);

    // Exce_ret forcing take low while disable=0 and a request is eligible
    irq_in = 3'b000;
    eret();
    bus.take_en = 1'b0;
    step(2);
    irq_in = 3'b001;
    step(3);
    bus.take_en  = 1'b1;
    bus.exce_ret = 1'b1;
    #1;
    chk("eret_force_low", {31'b0, bus.irq_take}, 32'h0);
    step();
    bus.exce_ret = 1'b0;
    #1;
    chk("eret_then_take", {31'b0, bus.irq_take}, 32'h1);
    step();

    // Masking: source 2 pends but waits until mask reopens
    irq_in = 3'b000;
    eret();
    bus.cp0_we    = 1'b1;
    bus.cp0_addr  = 5'h17;
    bus.cp0_wdata = 32'h1;
    step();
    bus.cp0_we = 1'b0;
    irq_in[2]  = 1'b1;
    step(3);
    #1;
    chk("mask_notake", {31'b0, bus.irq_take}, 32'h0);
    rd("mask_pend", 5'h0d, 32'h4);
    bus.cp0_we    = 1'b1;
    bus.cp0_addr  = 5'h17;
    bus.cp0_wdata = 32'h7;
    #1;
    chk("mask_wr_cycle", {31'b0, bus.irq_take}, 32'h0);
    step();
    bus.cp0_we = 1'b0;
    #1;
    chk("mask_take", {31'b0, bus.irq_take}, 32'h1);
    chk("mask_tgt", bus.irq_target, 32'h0000_0400);
    step();

    // take_en low holds the request
    irq_in = 3'b000;
    eret();
    bus.take_en = 1'b0;
    step(2);
    irq_in = 3'b010;
    step(3);
    n_take = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.irq_take) n_take++;
      step();
    end
    chk("hold_notake", 32'(n_take), 32'd0);
    rd("hold_pend", 5'h0d, 32'h2);
    bus.take_en = 1'b1;
    #1;
    chk("hold_take", {31'b0, bus.irq_take}, 32'h1);
    chk("hold_tgt", bus.irq_target, 32'h0000_0600);
    step();
    bus.take_en = 1'b0;

    // Write priority and set-wins on pending
    eret();
    irq_in = 3'b000;
    step(2);
    irq_in = 3'b010;
    step(3);
    irq_in = 3'b000;
    step(3);
    irq_in = 3'b010;
    step(2);
    bus.take_en   = 1'b1;
    bus.cp0_we    = 1'b1;
    bus.cp0_addr  = 5'h16;
    bus.cp0_wdata = 32'h0;
    bus.resume_pc = 32'h0000_0088;
    #1;
    chk("prio_take", {31'b0, bus.irq_take}, 32'h1);
    step();
    bus.cp0_we  = 1'b0;
    bus.take_en = 1'b0;
    rd("prio_dis", 5'h16, 32'h1);
    rd("setwins_pend", 5'h0d, 32'h2);
    rd("prio_epc_take", 5'h0e, 32'h0000_0088);
    eret();
    bus.take_en   = 1'b1;
    bus.cp0_we    = 1'b1;
    bus.cp0_addr  = 5'h0e;
    bus.cp0_wdata = 32'hDEAD_BEEF;
    bus.resume_pc = 32'h0000_0099;
    #1;
    chk("prio_take2", {31'b0, bus.irq_take}, 32'h1);
    step();
    bus.cp0_we  = 1'b0;
    bus.take_en = 1'b0;
    rd("prio_epc_lost", 5'h0e, 32'h0000_0099);
    rd("prio_pend_clr", 5'h0d, 32'h0);

    // Asynchronous reset mid-operation
    irq_in = 3'b000;
    step(3);
    irq_in = 3'b010;
    step(3);
    rd("pre_rst_pend", 5'h0d, 32'h2);
    rst_n = 1'b0;
    rd("async_rst_pend", 5'h0d, 32'h0);
    rd("async_rst_dis",  5'h16, 32'h0);
    rd("async_rst_mask", 5'h17, 32'h7);
    rd("async_rst_epc",  5'h0e, 32'h0);
    irq_in = 3'b000;
    step(2);
    rst_n = 1'b1;
    step();
    rd("post_rst_pend", 5'h0d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
